// File: rtl/jk_response_checker.sv
// Checks an observed JK flip-flop against a one-cycle-ahead model, counting errors and toggles.
// Optional JK_CHK_QBAR_EN: also flags qbar that does not complement q during CHECK.
module jk_response_checker #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             check_en,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  input  logic             qbar,
  output logic             exp_q,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] toggle_count,
  output logic             halted,
  output logic             active
);

  typedef enum logic [1:0] {StIdle, StSeed, StCheck, StHalt} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state;
  logic             r_exp_q;
  logic             r_mismatch;
  logic             r_halted;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_toggle_count;

  logic             w_next_q;
  logic             w_error;
  logic             w_toggle;
  logic [CNT_W-1:0] w_toggle_inc;

  always_comb begin
    w_next_q = q;
    unique case ({j, k})
      2'b00: w_next_q = q;
      2'b01: w_next_q = 1'b0;
      2'b10: w_next_q = 1'b1;
      2'b11: w_next_q = ~q;
    endcase
  end

`ifdef JK_CHK_QBAR_EN
  assign w_error = (q != r_exp_q) || (qbar != ~q);
`else
  logic w_unused_qbar;
  assign w_unused_qbar = qbar;
  assign w_error       = (q != r_exp_q);
`endif

  assign w_toggle     = j & k;
  assign w_toggle_inc = (r_toggle_count == CntMax) ? r_toggle_count : r_toggle_count + 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= StIdle;
      r_exp_q        <= 1'b0;
      r_mismatch     <= 1'b0;
      r_halted       <= 1'b0;
      r_err_count    <= '0;
      r_toggle_count <= '0;
    end else begin
      r_mismatch <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (check_en) r_state <= StSeed;
        end
        StSeed: begin
          r_exp_q <= w_next_q;
          if (w_toggle) r_toggle_count <= w_toggle_inc;
          r_state <= check_en ? StCheck : StIdle;
        end
        StCheck: begin
          if (!check_en) begin
            r_state <= StIdle;
          end else begin
            // The model resyncs to observed q, so a single fault is counted once.
            r_mismatch <= w_error;
            r_exp_q    <= w_next_q;
            if (w_toggle) r_toggle_count <= w_toggle_inc;
            if (w_error) begin
              r_err_count <= r_err_count + 1'b1;
              if (r_err_count == CntMax - 1'b1) begin
                r_state  <= StHalt;
                r_halted <= 1'b1;
              end
            end
          end
        end
        StHalt: r_state <= StHalt;
      endcase
    end
  end

  assign exp_q        = r_exp_q;
  assign mismatch     = r_mismatch;
  assign err_count    = r_err_count;
  assign toggle_count = r_toggle_count;
  assign halted       = r_halted;
  assign active       = (r_state == StSeed) || (r_state == StCheck);

endmodule

// File: tb/tb_jk_response_checker.sv
// Bench for jk_response_checker: a wide (CNT_W=8) and a narrow (CNT_W=2) instance share stimulus.
module tb_jk_response_checker;

  logic clock = 1'b0;
  logic reset, check_en, j, k, q, qbar;

  logic       l_exp, l_mis, l_halt, l_act;
  logic [7:0] l_err, l_tog;
  logic       s_exp, s_mis, s_halt, s_act;
  logic [1:0] s_err, s_tog;

  logic       d_exp[2], d_mis[2], d_halt[2], d_act[2];
  logic [7:0] d_err[2], d_tog[2];

  int n_vec = 0;
  int n_bad = 0;

  // Stimulus-side JK flop and fault controls.
  bit ff_q = 1'b0;
  bit fault_en = 1'b0;
  bit fault_val = 1'b0;
  bit qbar_bad = 1'b0;

  // Reference model state, one slot per instance.
  int max_cnt[2] = '{255, 3};
  bit m_live[2], m_pred_ok[2], m_halt[2], m_exp[2], m_mis[2];
  int m_err[2], m_tog[2];

  assign q    = fault_en ? fault_val : ff_q;
  assign qbar = qbar_bad ? q : ~q;

  assign d_exp[0] = l_exp;  assign d_mis[0] = l_mis;  assign d_halt[0] = l_halt;
  assign d_act[0] = l_act;  assign d_err[0] = l_err;  assign d_tog[0]  = l_tog;
  assign d_exp[1] = s_exp;  assign d_mis[1] = s_mis;  assign d_halt[1] = s_halt;
  assign d_act[1] = s_act;  assign d_err[1] = {6'b0, s_err};  assign d_tog[1] = {6'b0, s_tog};

  jk_response_checker #(.CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .check_en(check_en), .j(j), .k(k), .q(q), .qbar(qbar),
    .exp_q(l_exp), .mismatch(l_mis), .err_count(l_err), .toggle_count(l_tog),
    .halted(l_halt), .active(l_act)
  );

  jk_response_checker #(.CNT_W(2)) u_dut_sat (
    .clock(clock), .reset(reset), .check_en(check_en), .j(j), .k(k), .q(q), .qbar(qbar),
    .exp_q(s_exp), .mismatch(s_mis), .err_count(s_err), .toggle_count(s_tog),
    .halted(s_halt), .active(s_act)
  );

  always #5 clock = ~clock;

  function automatic bit jk_next(bit qq, bit jj, bit kk);
    if (jj && kk) return ~qq;
    if (jj) return 1'b1;
    if (kk) return 1'b0;
    return qq;
  endfunction

  // One rising edge: snapshot inputs, then advance the JK flop and the checker model.
  task automatic step();
    bit r, e, jj, kk, qq, qb, err;
    @(posedge clock);
    r = reset; e = check_en; jj = j; kk = k; qq = q; qb = qbar;
    #1;
    ff_q = jk_next(ff_q, jj, kk);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_live[i] = 0; m_pred_ok[i] = 0; m_halt[i] = 0; m_exp[i] = 0;
        m_mis[i] = 0; m_err[i] = 0; m_tog[i] = 0;
      end else if (m_halt[i]) begin
        m_mis[i] = 0;
      end else begin
        m_mis[i] = 0;
        if (!m_live[i]) begin
          m_live[i] = e;
          m_pred_ok[i] = 0;
        end else if (m_pred_ok[i] && !e) begin
          m_live[i] = 0;
        end else begin
          if (m_pred_ok[i]) begin
            err = (qq != m_exp[i]);
`ifdef JK_CHK_QBAR_EN
            err = err || (qb == qq);
`endif
            m_mis[i] = err;
            if (err) begin
              m_err[i]++;
              if (m_err[i] == max_cnt[i]) m_halt[i] = 1;
            end
          end
          m_exp[i] = jk_next(qq, jj, kk);
          if (jj && kk && m_tog[i] < max_cnt[i]) m_tog[i]++;
          if (!m_pred_ok[i]) begin
            m_pred_ok[i] = e;
            m_live[i] = e;
          end
        end
      end
    end
  endtask

  task automatic reset_pulse();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; check_en = 1'b1; j = 1'b1; k = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({d_exp[i], d_mis[i], d_halt[i], d_act[i]} !== 4'b0 || d_err[i] !== 8'd0 ||
          d_tog[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset inst%0d: got exp=%b mis=%b halt=%b act=%b err=%0d tog=%0d, need all 0",
                 i, d_exp[i], d_mis[i], d_halt[i], d_act[i], d_err[i], d_tog[i]);
      end
    end
  endtask

  task automatic test_correct_dut();
    reset = 1'b1; check_en = 1'b1; j = 1'b1; k = 1'b0;
    step(); step();
    j = 1'b0; k = 1'b1;
    step();
    j = 1'b1; k = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_vec++;
      if (d_mis[0] !== 1'b0 || d_mis[1] !== 1'b0) begin
        n_bad++;
        $display("FAIL correct_mis cycle %0d: got %b/%b, need 0/0", c, d_mis[0], d_mis[1]);
      end
    end
    n_vec++;
    if (d_err[0] !== 8'd0 || d_tog[0] !== 8'd4 || d_act[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL correct_counts: got err=%0d tog=%0d act=%b, need err=0 tog=4 act=1",
               d_err[0], d_tog[0], d_act[0]);
    end
    n_vec++;
    if (d_tog[1] !== 8'd3 || d_halt[1] !== 1'b0 || d_act[1] !== 1'b1) begin
      n_bad++;
      $display("FAIL toggle_sat: got tog=%0d halt=%b act=%b, need tog=3 halt=0 act=1",
               d_tog[1], d_halt[1], d_act[1]);
    end
  endtask

  task automatic test_stuck_and_saturation();
    reset_pulse();
    check_en = 1'b1; j = 1'b1; k = 1'b0; fault_en = 1'b1; fault_val = 1'b0;
    step(); step();
    for (int c = 1; c <= 5; c++) begin
      n_vec++;
      if (d_exp[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL stuck_exp before compare %0d: got %b, need 1", c, d_exp[0]);
      end
      step();
      n_vec++;
      if (d_mis[0] !== 1'b1 || d_err[0] !== 8'(c)) begin
        n_bad++;
        $display("FAIL stuck compare %0d: got mis=%b err=%0d, need mis=1 err=%0d",
                 c, d_mis[0], d_err[0], c);
      end
      n_vec++;
      if (d_err[1] !== 8'((c < 3) ? c : 3) || d_halt[1] !== (c >= 3) ||
          d_mis[1] !== (c <= 3)) begin
        n_bad++;
        $display("FAIL saturate compare %0d: got err=%0d halt=%b mis=%b, need err=%0d halt=%b mis=%b",
                 c, d_err[1], d_halt[1], d_mis[1], (c < 3) ? c : 3, c >= 3, c <= 3);
      end
    end
    for (int c = 0; c < 4; c++) begin
      j = 1'($urandom); k = 1'($urandom); fault_val = 1'($urandom);
      step();
      n_vec++;
      if (d_halt[1] !== 1'b1 || d_act[1] !== 1'b0 || d_mis[1] !== 1'b0 ||
          d_err[1] !== 8'd3 || d_exp[1] !== 1'b1 || d_tog[1] !== 8'(m_tog[1])) begin
        n_bad++;
        $display("FAIL halt_hold %0d: got halt=%b act=%b mis=%b err=%0d exp=%b tog=%0d, need 1 0 0 3 1 %0d",
                 c, d_halt[1], d_act[1], d_mis[1], d_err[1], d_exp[1], d_tog[1], m_tog[1]);
      end
    end
    fault_en = 1'b0;
  endtask

  task automatic test_pause();
    reset_pulse();
    check_en = 1'b1; j = 1'b1; k = 1'b0; fault_en = 1'b1; fault_val = 1'b0;
    repeat (4) step();
    check_en = 1'b0; j = 1'b1; k = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      n_vec++;
      if (d_mis[0] !== 1'b0 || d_err[0] !== 8'd2 || d_tog[0] !== 8'd0 || d_act[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL pause %0d: got mis=%b err=%0d tog=%0d act=%b, need 0 2 0 0",
                 c, d_mis[0], d_err[0], d_tog[0], d_act[0]);
      end
    end
    check_en = 1'b1; j = 1'b1; k = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      n_vec++;
      if (d_mis[0] !== 1'b0 || d_err[0] !== 8'd2 || d_act[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL reseed %0d: got mis=%b err=%0d act=%b, need 0 2 1",
                 c, d_mis[0], d_err[0], d_act[0]);
      end
    end
    step();
    n_vec++;
    if (d_mis[0] !== 1'b1 || d_err[0] !== 8'd3) begin
      n_bad++;
      $display("FAIL resume: got mis=%b err=%0d, need mis=1 err=3", d_mis[0], d_err[0]);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_reset_on_error();
    reset_pulse();
    check_en = 1'b1; j = 1'b1; k = 1'b0; fault_en = 1'b1; fault_val = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if ({d_exp[i], d_mis[i], d_halt[i], d_act[i]} !== 4'b0 || d_err[i] !== 8'd0 ||
          d_tog[i] !== 8'd0) begin
        n_bad++;
        $display("FAIL reset_on_error inst%0d: got exp=%b mis=%b halt=%b act=%b err=%0d, need all 0",
                 i, d_exp[i], d_mis[i], d_halt[i], d_act[i], d_err[i]);
      end
    end
    reset = 1'b1;
    step(); step();
    n_vec++;
    if (d_mis[0] !== 1'b0 || d_err[0] !== 8'd0) begin
      n_bad++;
      $display("FAIL fresh_seed: got mis=%b err=%0d, need 0 0", d_mis[0], d_err[0]);
    end
    step();
    n_vec++;
    if (d_mis[0] !== 1'b1 || d_err[0] !== 8'd1) begin
      n_bad++;
      $display("FAIL first_compare: got mis=%b err=%0d, need 1 1", d_mis[0], d_err[0]);
    end
    fault_en = 1'b0;
  endtask

  task automatic test_qbar();
    int want;
`ifdef JK_CHK_QBAR_EN
    want = 2;
`else
    want = 0;
`endif
    reset_pulse();
    check_en = 1'b1; j = 1'b0; k = 1'b0; fault_en = 1'b0;
    step(); step();
    qbar_bad = 1'b1;
    step(); step();
    qbar_bad = 1'b0;
    step();
    n_vec++;
    if (d_err[0] !== 8'(want)) begin
      n_bad++;
      $display("FAIL qbar: got err=%0d, need %0d", d_err[0], want);
    end
  endtask

  task automatic test_random();
    reset_pulse();
    for (int c = 0; c < 400; c++) begin
      reset     = ($urandom_range(0, 49) != 0);
      check_en  = ($urandom_range(0, 7) != 0);
      j         = 1'($urandom);
      k         = 1'($urandom);
      fault_en  = ($urandom_range(0, 5) == 0);
      fault_val = 1'($urandom);
      qbar_bad  = ($urandom_range(0, 9) == 0);
      step();
      for (int i = 0; i < 2; i++) begin
        n_vec++;
        if (d_exp[i] !== m_exp[i] || d_mis[i] !== m_mis[i] || d_halt[i] !== m_halt[i] ||
            d_act[i] !== (m_live[i] && !m_halt[i]) || d_err[i] !== 8'(m_err[i]) ||
            d_tog[i] !== 8'(m_tog[i])) begin
          n_bad++;
          $display("FAIL random c%0d inst%0d: got exp=%b mis=%b halt=%b act=%b err=%0d tog=%0d, need %b %b %b %b %0d %0d",
                   c, i, d_exp[i], d_mis[i], d_halt[i], d_act[i], d_err[i], d_tog[i],
                   m_exp[i], m_mis[i], m_halt[i], m_live[i] && !m_halt[i], m_err[i], m_tog[i]);
        end
      end
    end
    fault_en = 1'b0; qbar_bad = 1'b0;
  endtask

  initial begin
    reset = 1'b0; check_en = 1'b0; j = 1'b0; k = 1'b0;
    test_reset();
    test_correct_dut();
    test_stuck_and_saturation();
    test_pause();
    test_reset_on_error();
    test_qbar();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/jk_response_checker.md
JK_RESPONSE_CHECKER -- requirements
Module: jk_response_checker

Interface
REQ-001 Parameter CNT_W, default 8, width of err_count and toggle_count.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clock.
REQ-004 check_en  input  1  1 = run checking; 0 = pause.
REQ-005 j  input  1  J input driven to the JK flip-flop under observation.
REQ-006 k  input  1  K input driven to the JK flip-flop under observation.
REQ-007 q  input  1  observed flip-flop output.
REQ-008 qbar  input  1  observed complementary output.
REQ-009 exp_q  output  1  registered model prediction of q for the current cycle.
REQ-010 mismatch  output  1  registered one-cycle pulse per detected error.
REQ-011 err_count  output  CNT_W  saturating error count.
REQ-012 toggle_count  output  CNT_W  saturating count of sampled j=k=1 cycles.
REQ-013 halted  output  1  1 once err_count has saturated.
REQ-014 active  output  1  1 in SEED or CHECK state.

Function
REQ-015 The FSM SHALL have four states: IDLE, SEED, CHECK, HALT.
REQ-016 IDLE: check_en=1 -> SEED; otherwise stay in IDLE, all counters and exp_q held.
REQ-017 SEED, one cycle: exp_q <= next(q,j,k); no compare; then -> CHECK if check_en=1, else -> IDLE.
REQ-018 next(q,j,k) SHALL be: 00 -> q, 01 -> 0, 10 -> 1, 11 -> ~q.
REQ-019 CHECK, each edge: error = (q != exp_q); mismatch <= error; exp_q <= next(q,j,k). Using the observed q resyncs the model, so one DUT fault counts once.
REQ-020 Latency: a prediction made at edge N SHALL be compared at edge N+1; mismatch is visible after edge N+1 for exactly one cycle.
REQ-021 err_count SHALL increment by 1 per error and saturate at 2^CNT_W-1; on the edge reaching saturation, the FSM SHALL go to HALT and halted <= 1.
REQ-022 toggle_count SHALL increment in SEED or CHECK when j=k=1 is sampled, saturating at 2^CNT_W-1 without halting.
REQ-023 CHECK with check_en=0 SHALL -> IDLE on that edge with no compare; mismatch <= 0; counters hold; re-enable passes through SEED again.
REQ-024 HALT SHALL be left only by reset; in HALT mismatch=0 and all counters and exp_q hold.
REQ-025 mismatch SHALL be 0 in every cycle not following a CHECK-state error.

Reset
REQ-026 reset=0 at a rising edge SHALL force IDLE, exp_q=0, mismatch=0, err_count=0, toggle_count=0, halted=0, active=0, in every state.
REQ-027 reset SHALL take precedence over check_en and over a simultaneous error or saturation.
REQ-028 Reset asserted mid-CHECK SHALL discard the pending prediction; the first compare after release follows a fresh SEED.

Configuration
REQ-029 Macro JK_CHK_QBAR_EN: defined -> in CHECK, error = (q != exp_q) OR (qbar != ~q), counted once per cycle; undefined -> qbar ignored, port retained.

Verification
REQ-030 Reset low 3 edges, then check_en=1, j,k=10 then 01 then 11 x4 on a correct DUT -> mismatch never 1, err_count=0, toggle_count=4.
REQ-031 DUT q forced stuck at 0 while j,k=10 for 5 CHECK cycles -> 5 one-cycle mismatch pulses, err_count=5, exp_q=1 on each compare.
REQ-032 CNT_W=2 with a persistently wrong q -> err_count 1,2,3, then halted=1 and state HALT, mismatch=0 afterwards, j,k changes ignored.
REQ-033 check_en dropped for 4 cycles mid-run while q is wrong -> no mismatch and counters frozen; re-enable -> one SEED cycle without compare, then checking resumes.
REQ-034 reset=0 pulsed on the same edge as an error -> all outputs 0, active=0, no err_count increment.
REQ-035 With JK_CHK_QBAR_EN, q correct and qbar=q for 2 cycles -> err_count=2; without the macro -> err_count=0.
